// File: rtl/controller.sv
// ============================================================================
//  Module      : controller
//  Description : Sequencer for a systolic array: weight-load phase, then a
//                skewed compute phase driving iact reads and psum writes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module controller #(
    parameter int ARRAY_ROWS = 3,
    parameter int ARRAY_COLS = 3,
    parameter int IACT_COLS  = ARRAY_ROWS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         go,
    output logic [31:0]                  weight_addr,
    output logic [0:ARRAY_COLS-1][31:0]  iact_addr,
    output logic [0:ARRAY_ROWS-1][31:0]  psum_addr,
    output logic                         load_weight,
    output logic [0:ARRAY_COLS-1]        load_iact,
    output logic [0:ARRAY_ROWS-1]        psum_valid,
    output logic                         done
);

    localparam int LOAD_WEIGHT_CYCLES = ARRAY_COLS;
    localparam int COMPUTE_CYCLES     = IACT_COLS + ARRAY_ROWS + ARRAY_COLS;

    localparam logic [31:0] c_lw_last      = 32'(LOAD_WEIGHT_CYCLES - 1);
    localparam logic [31:0] c_compute_last = 32'(COMPUTE_CYCLES - 1);
    localparam logic [31:0] c_window_len   = 32'(IACT_COLS);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        LOAD_WEIGHT = 2'd1,
        COMPUTE     = 2'd2,
        DONE        = 2'd3
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [31:0] load_weight_cycle_cnt;
    logic [31:0] load_weight_cycle_cnt_d;
    logic [31:0] compute_cycle_cnt;
    logic [31:0] compute_cycle_cnt_d;

    logic        w_in_load;
    logic        w_in_compute;

    // ------------------------------------------------------------------
    // Next-state and counter update
    // ------------------------------------------------------------------
    always_comb begin
        state_d                 = state;
        load_weight_cycle_cnt_d = load_weight_cycle_cnt;
        compute_cycle_cnt_d     = compute_cycle_cnt;
        case (state)
            IDLE: begin
                if (go) begin
                    state_d                 = LOAD_WEIGHT;
                    load_weight_cycle_cnt_d = '0;
                end
            end
            LOAD_WEIGHT: begin
                load_weight_cycle_cnt_d = load_weight_cycle_cnt + 32'd1;
                if (load_weight_cycle_cnt == c_lw_last) begin
                    state_d             = COMPUTE;
                    compute_cycle_cnt_d = '0;
                end
            end
            COMPUTE: begin
                compute_cycle_cnt_d = compute_cycle_cnt + 32'd1;
                if (compute_cycle_cnt == c_compute_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                 <= IDLE;
            load_weight_cycle_cnt <= '0;
            compute_cycle_cnt     <= '0;
        end else begin
            state                 <= state_d;
            load_weight_cycle_cnt <= load_weight_cycle_cnt_d;
            compute_cycle_cnt     <= compute_cycle_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    assign w_in_load    = (state == LOAD_WEIGHT);
    assign w_in_compute = (state == COMPUTE);

    assign load_weight = w_in_load;
    assign weight_addr = w_in_load ? load_weight_cycle_cnt : '0;
    assign done        = (state == DONE);

    // Window test uses the wrapped offset: a count below the window start
    // wraps to a huge value, so one unsigned compare covers both bounds and
    // the offset doubles as the address inside the window.
    generate
        for (genvar c = 0; c < ARRAY_COLS; c++) begin : g_iact
            localparam logic [31:0] c_start = 32'(c);
            logic [31:0] w_offset;

            assign w_offset     = compute_cycle_cnt - c_start;
            assign load_iact[c] = w_in_compute && (w_offset < c_window_len);
            assign iact_addr[c] = load_iact[c] ? w_offset : '0;
        end

        for (genvar r = 0; r < ARRAY_ROWS; r++) begin : g_psum
            localparam logic [31:0] c_start = 32'(ARRAY_COLS + r);
            logic [31:0] w_offset;

            assign w_offset      = compute_cycle_cnt - c_start;
            assign psum_valid[r] = w_in_compute && (w_offset < c_window_len);
            assign psum_addr[r]  = psum_valid[r] ? w_offset : '0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_controller.sv
// ============================================================================
//  Module      : tb_controller
//  Description : Self-checking bench for controller with a run-time based
//                reference model and directed plus random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controller;

    localparam int ROWS    = 3;
    localparam int COLS    = 3;
    localparam int IACT    = ROWS;
    localparam int COMPUTE = IACT + ROWS + COLS;
    localparam int TOTAL   = 1 + COLS + COMPUTE;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    go;
    logic [31:0]             weight_addr;
    logic [0:COLS-1][31:0]   iact_addr;
    logic [0:ROWS-1][31:0]   psum_addr;
    logic                    load_weight;
    logic [0:COLS-1]         load_iact;
    logic [0:ROWS-1]         psum_valid;
    logic                    done;

    int checks   = 0;
    int failures = 0;

    // Model: busy flag plus number of cycles since the go-sampling edge.
    bit m_busy = 1'b0;
    int m_t    = 0;

    always #5 clk = ~clk;

    controller #(
        .ARRAY_ROWS (ROWS),
        .ARRAY_COLS (COLS),
        .IACT_COLS  (IACT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .go          (go),
        .weight_addr (weight_addr),
        .iact_addr   (iact_addr),
        .psum_addr   (psum_addr),
        .load_weight (load_weight),
        .load_iact   (load_iact),
        .psum_valid  (psum_valid),
        .done        (done)
    );

    task automatic tick(input logic g, input logic rn);
        go    = g;
        rst_n = rn;
        @(posedge clk);
        if (!rn) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (m_t == TOTAL) m_busy = 1'b0;
            else              m_t++;
        end else if (g) begin
            m_busy = 1'b1;
            m_t    = 1;
        end
        @(negedge clk);
    endtask

    task automatic model_expect(output logic e_lw, output logic [31:0] e_wa,
                                output logic [0:COLS-1] e_li,
                                output logic [0:COLS-1][31:0] e_ia,
                                output logic [0:ROWS-1] e_pv,
                                output logic [0:ROWS-1][31:0] e_pa,
                                output logic e_done);
        int k;
        e_lw = 1'b0; e_wa = '0; e_li = '0; e_ia = '0; e_pv = '0; e_pa = '0;
        e_done = m_busy && (m_t == TOTAL);
        if (m_busy && m_t <= COLS) begin
            e_lw = 1'b1;
            e_wa = 32'(m_t - 1);
        end
        if (m_busy && m_t > COLS && m_t <= COLS + COMPUTE) begin
            k = m_t - 1 - COLS;
            for (int c = 0; c < COLS; c++) begin
                if (k >= c && k < c + IACT) begin
                    e_li[c] = 1'b1;
                    e_ia[c] = 32'(k - c);
                end
            end
            for (int r = 0; r < ROWS; r++) begin
                if (k >= COLS + r && k < COLS + r + IACT) begin
                    e_pv[r] = 1'b1;
                    e_pa[r] = 32'(k - COLS - r);
                end
            end
        end
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        checks++;
        if ({weight_addr, iact_addr, psum_addr, load_weight, load_iact, psum_valid, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got wa=%h li=%b ia=%h pv=%b pa=%h lw=%b done=%b, want all zero",
                     weight_addr, load_iact, iact_addr, psum_valid, psum_addr, load_weight, done);
        end
        checks++;
        if (dut.load_weight_cycle_cnt !== 32'd0 || dut.compute_cycle_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_counters: got lw_cnt=%0d cp_cnt=%0d, want 0 0",
                     dut.load_weight_cycle_cnt, dut.compute_cycle_cnt);
        end
    endtask

    task automatic test_weight_load();
        for (int i = 0; i < COLS; i++) begin
            // First tick samples go; the second keeps go high to prove it is ignored
            tick(i < 2, 1'b1);
            checks++;
            if (load_weight !== 1'b1 || weight_addr !== 32'(i)) begin
                failures++;
                $display("FAIL weight_load[%0d]: got lw=%b addr=%0d, want lw=1 addr=%0d",
                         i, load_weight, weight_addr, i);
            end
        end
    endtask

    task automatic test_compute_windows();
        logic [0:COLS-1][31:0] ia_exp;
        logic [0:ROWS-1][31:0] pa_exp;
        for (int k = 0; k < COMPUTE; k++) begin
            tick(k % 2 == 1, 1'b1);
            case (k)
                0: begin
                    checks++;
                    if (load_weight !== 1'b0 || dut.compute_cycle_cnt !== 32'd0) begin
                        failures++;
                        $display("FAIL compute_entry: got lw=%b cnt=%0d, want lw=0 cnt=0",
                                 load_weight, dut.compute_cycle_cnt);
                    end
                    ia_exp = '0;
                    checks++;
                    if (load_iact !== 3'b100 || iact_addr !== ia_exp) begin
                        failures++;
                        $display("FAIL iact_cnt0: got li=%b ia=%h, want li=100 ia=%h", load_iact, iact_addr, ia_exp);
                    end
                end
                2: begin
                    ia_exp = {32'd2, 32'd1, 32'd0};
                    checks++;
                    if (load_iact !== 3'b111 || iact_addr !== ia_exp) begin
                        failures++;
                        $display("FAIL iact_cnt2: got li=%b ia=%h, want li=111 ia=%h", load_iact, iact_addr, ia_exp);
                    end
                end
                3: begin
                    checks++;
                    if (psum_valid !== 3'b100) begin
                        failures++;
                        $display("FAIL psum_cnt3: got pv=%b, want 100", psum_valid);
                    end
                end
                4: begin
                    ia_exp = {32'd0, 32'd0, 32'd2};
                    checks++;
                    if (load_iact !== 3'b001 || iact_addr !== ia_exp) begin
                        failures++;
                        $display("FAIL iact_cnt4: got li=%b ia=%h, want li=001 ia=%h", load_iact, iact_addr, ia_exp);
                    end
                end
                5: begin
                    checks++;
                    if (load_iact !== 3'b000) begin
                        failures++;
                        $display("FAIL iact_cnt5: got li=%b, want 000", load_iact);
                    end
                    pa_exp = {32'd2, 32'd1, 32'd0};
                    checks++;
                    if (psum_valid !== 3'b111 || psum_addr !== pa_exp) begin
                        failures++;
                        $display("FAIL psum_cnt5: got pv=%b pa=%h, want pv=111 pa=%h", psum_valid, psum_addr, pa_exp);
                    end
                end
                7: begin
                    pa_exp = {32'd0, 32'd0, 32'd2};
                    checks++;
                    if (psum_valid !== 3'b001 || psum_addr !== pa_exp) begin
                        failures++;
                        $display("FAIL psum_cnt7: got pv=%b pa=%h, want pv=001 pa=%h", psum_valid, psum_addr, pa_exp);
                    end
                end
                8: begin
                    checks++;
                    if (psum_valid !== 3'b000 || done !== 1'b0) begin
                        failures++;
                        $display("FAIL psum_cnt8: got pv=%b done=%b, want pv=000 done=0", psum_valid, done);
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_completion();
        // Thirteenth cycle after the go-sampling edge
        tick(1'b0, 1'b1);
        checks++;
        if (done !== 1'b1 || {load_weight, load_iact, psum_valid} !== '0) begin
            failures++;
            $display("FAIL done_cycle: got done=%b lw=%b li=%b pv=%b, want done=1 others 0",
                     done, load_weight, load_iact, psum_valid);
        end
        tick(1'b0, 1'b1);
        checks++;
        if ({weight_addr, iact_addr, psum_addr, load_weight, load_iact, psum_valid, done} !== '0) begin
            failures++;
            $display("FAIL after_done_idle: got done=%b lw=%b li=%b pv=%b, want all zero",
                     done, load_weight, load_iact, psum_valid);
        end
        tick(1'b0, 1'b1);
        checks++;
        if (load_weight !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL stays_idle: got lw=%b done=%b, want 0 0", load_weight, done);
        end
    endtask

    task automatic test_mid_reset();
        logic [0:COLS-1][31:0] ia_exp;
        tick(1'b1, 1'b1);
        for (int i = 0; i < COLS - 1 + 4 + 1; i++) tick(1'b0, 1'b1);
        ia_exp = {32'd0, 32'd0, 32'd2};
        checks++;
        if (load_iact !== 3'b001 || iact_addr !== ia_exp) begin
            failures++;
            $display("FAIL mid_reset_setup: got li=%b ia=%h, want li=001 ia=%h", load_iact, iact_addr, ia_exp);
        end
        tick(1'b0, 1'b0);
        checks++;
        if ({weight_addr, iact_addr, psum_addr, load_weight, load_iact, psum_valid, done} !== '0
            || dut.compute_cycle_cnt !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got li=%b pv=%b lw=%b done=%b cnt=%0d, want all zero",
                     load_iact, psum_valid, load_weight, done, dut.compute_cycle_cnt);
        end
        tick(1'b1, 1'b1);
        checks++;
        if (load_weight !== 1'b1 || weight_addr !== 32'd0) begin
            failures++;
            $display("FAIL restart: got lw=%b addr=%0d, want lw=1 addr=0", load_weight, weight_addr);
        end
        for (int i = 0; i < TOTAL + 1; i++) tick(1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        logic exp_done;
        tick(1'b0, 1'b0);
        for (int n = 1; n <= 2 * TOTAL + 2; n++) begin
            tick(1'b1, 1'b1);
            exp_done = (n == TOTAL) || (n == 2 * TOTAL + 1);
            if (done === 1'b1) dones++;
            checks++;
            if (done !== exp_done) begin
                failures++;
                $display("FAIL b2b_done[%0d]: got %b, want %b", n, done, exp_done);
            end
            if (n == TOTAL + 1 || n == TOTAL + 2) begin
                checks++;
                if (load_weight !== (n == TOTAL + 2) || weight_addr !== 32'd0) begin
                    failures++;
                    $display("FAIL b2b_gap[%0d]: got lw=%b addr=%0d, want lw=%b addr=0",
                             n, load_weight, weight_addr, n == TOTAL + 2);
                end
            end
        end
        checks++;
        if (dones != 2) begin
            failures++;
            $display("FAIL b2b_count: got %0d done pulses, want 2", dones);
        end
    endtask

    task automatic test_random();
        logic                  e_lw, e_done;
        logic [31:0]           e_wa;
        logic [0:COLS-1]       e_li;
        logic [0:COLS-1][31:0] e_ia;
        logic [0:ROWS-1]       e_pv;
        logic [0:ROWS-1][31:0] e_pa;
        tick(1'b0, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            tick($urandom_range(0, 99) < 30, $urandom_range(0, 99) >= 3);
            model_expect(e_lw, e_wa, e_li, e_ia, e_pv, e_pa, e_done);
            checks++;
            if (load_weight !== e_lw || weight_addr !== e_wa) begin
                failures++;
                $display("FAIL rand_weight[%0d]: got lw=%b wa=%0d, want lw=%b wa=%0d",
                         i, load_weight, weight_addr, e_lw, e_wa);
            end
            checks++;
            if (load_iact !== e_li || iact_addr !== e_ia) begin
                failures++;
                $display("FAIL rand_iact[%0d]: got li=%b ia=%h, want li=%b ia=%h",
                         i, load_iact, iact_addr, e_li, e_ia);
            end
            checks++;
            if (psum_valid !== e_pv || psum_addr !== e_pa) begin
                failures++;
                $display("FAIL rand_psum[%0d]: got pv=%b pa=%h, want pv=%b pa=%h",
                         i, psum_valid, psum_addr, e_pv, e_pa);
            end
            checks++;
            if (done !== e_done) begin
                failures++;
                $display("FAIL rand_done[%0d]: got %b, want %b", i, done, e_done);
            end
        end
    endtask

    initial begin
        go    = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_weight_load();
        test_compute_windows();
        test_completion();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
